// File: rtl/traffic_pkg.sv
// Shared lamp encodings and fault codes for the traffic conflict monitor.
package traffic_pkg;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  localparam logic [2:0] NONE      = 3'd0;
  localparam logic [2:0] CONFLICT  = 3'd1;
  localparam logic [2:0] INVALID   = 3'd2;
  localparam logic [2:0] BAD_SEQ   = 3'd3;
  localparam logic [2:0] SHORT_YEL = 3'd4;
  localparam logic [2:0] STUCK     = 3'd5;

  function automatic logic lamp_valid(input logic [2:0] lamp);
    return (lamp == RED) || (lamp == YEL) || (lamp == GRN);
  endfunction

endpackage

// File: rtl/lamp_sequence_checker.sv
// Per-bundle checker: tracks the previous lamp value and yellow duration and flags
// invalid values, illegal transitions and short yellows.
module lamp_sequence_checker
  import traffic_pkg::*;
#(
  parameter int unsigned MIN_YELLOW = 3
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [2:0] lamp_i,
  output logic [2:0] prev_o,
  output logic       invalid_o,
  output logic       bad_seq_o,
  output logic       short_yel_o
);

  localparam int unsigned CW = (MIN_YELLOW > 0) ? $clog2(MIN_YELLOW + 1) : 1;

  logic [2:0]    prev_q;
  logic [CW-1:0] yel_cnt_q, yel_cnt_d;
  logic          legal_step;

  always_comb begin
    yel_cnt_d = '0;
    if (lamp_i == YEL) begin
      yel_cnt_d = (yel_cnt_q == CW'(MIN_YELLOW)) ? yel_cnt_q : yel_cnt_q + 1'b1;
    end
  end

  always_comb begin
    legal_step = (prev_q == lamp_i) ||
                 ((prev_q == RED) && (lamp_i == GRN)) ||
                 ((prev_q == GRN) && (lamp_i == YEL)) ||
                 ((prev_q == YEL) && (lamp_i == RED));
    invalid_o   = !lamp_valid(lamp_i);
    // Transitions touching an invalid value are reported as INVALID only.
    bad_seq_o   = lamp_valid(prev_q) && lamp_valid(lamp_i) && !legal_step;
    short_yel_o = (prev_q == YEL) && (lamp_i == RED) && (yel_cnt_q < CW'(MIN_YELLOW));
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      prev_q    <= RED;
      yel_cnt_q <= '0;
    end else begin
      prev_q    <= lamp_i;
      yel_cnt_q <= yel_cnt_d;
    end
  end

  assign prev_o = prev_q;

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Watches NS/EW lamp bundles for conflicts, illegal sequencing and a stuck controller,
// latching the first fault and requesting all-red flash.
module traffic_conflict_monitor
  import traffic_pkg::*;
#(
  parameter int unsigned MIN_YELLOW  = 3,
  parameter int unsigned STUCK_LIMIT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] NS,
  input  logic [2:0] EW,
  input  logic       fault_clr,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       flash_req,
  output logic [7:0] fault_cnt
);

  localparam int unsigned SW = $clog2(STUCK_LIMIT + 1);

  logic [2:0]    ns_prev, ew_prev;
  logic          ns_invalid, ns_bad_seq, ns_short_yel;
  logic          ew_invalid, ew_bad_seq, ew_short_yel;
  logic          unchanged, conflict, stuck_hit, any_viol;
  logic [2:0]    win_code;
  logic [SW-1:0] stuck_cnt_q, stuck_cnt_d;
  logic          fault_q, fault_d;
  logic [2:0]    code_q, code_d;
  logic [7:0]    cnt_q, cnt_d;

  lamp_sequence_checker #(.MIN_YELLOW(MIN_YELLOW)) u_ns_checker (
    .clk_i       (clk),
    .reset_i     (reset),
    .lamp_i      (NS),
    .prev_o      (ns_prev),
    .invalid_o   (ns_invalid),
    .bad_seq_o   (ns_bad_seq),
    .short_yel_o (ns_short_yel)
  );

  lamp_sequence_checker #(.MIN_YELLOW(MIN_YELLOW)) u_ew_checker (
    .clk_i       (clk),
    .reset_i     (reset),
    .lamp_i      (EW),
    .prev_o      (ew_prev),
    .invalid_o   (ew_invalid),
    .bad_seq_o   (ew_bad_seq),
    .short_yel_o (ew_short_yel)
  );

  always_comb begin
    unchanged   = ({NS, EW} == {ns_prev, ew_prev});
    stuck_cnt_d = '0;
    if (unchanged) begin
      stuck_cnt_d = (stuck_cnt_q == SW'(STUCK_LIMIT)) ? stuck_cnt_q : stuck_cnt_q + 1'b1;
    end
    // The current unchanged cycle counts toward the limit.
    stuck_hit = unchanged && (stuck_cnt_q >= SW'(STUCK_LIMIT - 1));
    conflict  = ((NS == YEL) || (NS == GRN)) && ((EW == YEL) || (EW == GRN));

    win_code = NONE;
    if (conflict)                          win_code = CONFLICT;
    else if (ns_invalid || ew_invalid)     win_code = INVALID;
    else if (ns_bad_seq || ew_bad_seq)     win_code = BAD_SEQ;
    else if (ns_short_yel || ew_short_yel) win_code = SHORT_YEL;
    else if (stuck_hit)                    win_code = STUCK;
    any_viol = (win_code != NONE);
  end

  always_comb begin
    fault_d = fault_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    if (!fault_q || fault_clr) begin
      if (any_viol) begin
        fault_d = 1'b1;
        code_d  = win_code;
        cnt_d   = (cnt_q == 8'hff) ? cnt_q : cnt_q + 8'd1;
      end else begin
        fault_d = 1'b0;
        code_d  = NONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stuck_cnt_q <= '0;
      fault_q     <= 1'b0;
      code_q      <= NONE;
      cnt_q       <= 8'd0;
    end else begin
      stuck_cnt_q <= stuck_cnt_d;
      fault_q     <= fault_d;
      code_q      <= code_d;
      cnt_q       <= cnt_d;
    end
  end

  assign fault      = fault_q;
  assign fault_code = code_q;
  assign flash_req  = fault_q;
  assign fault_cnt  = cnt_q;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Directed self-checking bench for traffic_conflict_monitor (MIN_YELLOW=3, STUCK_LIMIT=64).
module tb_traffic_conflict_monitor;
  import traffic_pkg::*;

  logic       clk;
  logic       reset;
  logic [2:0] NS, EW;
  logic       fault_clr;
  logic       fault;
  logic [2:0] fault_code;
  logic       flash_req;
  logic [7:0] fault_cnt;

  int checks;
  int errors;

  traffic_conflict_monitor #(.MIN_YELLOW(3), .STUCK_LIMIT(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .NS         (NS),
    .EW         (EW),
    .fault_clr  (fault_clr),
    .fault      (fault),
    .fault_code (fault_code),
    .flash_req  (flash_req),
    .fault_cnt  (fault_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic [2:0] ns, input logic [2:0] ew, input logic clr);
    NS        = ns;
    EW        = ew;
    fault_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic f, input logic [2:0] code,
                            input logic [7:0] cnt);
    check({tag, ".fault"}, {7'd0, fault}, {7'd0, f});
    check({tag, ".code"}, {5'd0, fault_code}, {5'd0, code});
    check({tag, ".flash"}, {7'd0, flash_req}, {7'd0, f});
    check({tag, ".cnt"}, fault_cnt, cnt);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step(RED, RED, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    NS        = RED;
    EW        = RED;
    fault_clr = 1'b0;
    step(RED, RED, 1'b0);
    step(RED, RED, 1'b0);
    expect_out("reset", 1'b0, NONE, 8'd0);
    reset = 1'b0;

    // Legal cycle: NS GRN5/YEL3, then EW GRN5/YEL3, four times
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < 5; i++) begin step(GRN, RED, 1'b0); check("legal_ns_grn", {7'd0, fault}, 8'd0); end
      for (int i = 0; i < 3; i++) begin step(YEL, RED, 1'b0); check("legal_ns_yel", {7'd0, fault}, 8'd0); end
      for (int i = 0; i < 5; i++) begin step(RED, GRN, 1'b0); check("legal_ew_grn", {7'd0, fault}, 8'd0); end
      for (int i = 0; i < 3; i++) begin step(RED, YEL, 1'b0); check("legal_ew_yel", {7'd0, fault}, 8'd0); end
    end
    step(RED, RED, 1'b0);
    expect_out("legal_end", 1'b0, NONE, 8'd0);

    // Conflict beats the simultaneous EW RED->YEL bad sequence
    step(GRN, YEL, 1'b0);
    expect_out("conflict", 1'b1, CONFLICT, 8'd1);

    // Reset wins over fault_clr and a live conflict
    reset = 1'b1;
    step(GRN, GRN, 1'b1);
    expect_out("reset_mid_fault", 1'b0, NONE, 8'd0);
    reset = 1'b0;

    // Short yellow together with invalid EW: INVALID wins
    step(GRN, RED, 1'b0);
    step(YEL, RED, 1'b0);
    step(YEL, RED, 1'b0);
    check("pre_short_yel", {7'd0, fault}, 8'd0);
    step(RED, 3'b110, 1'b0);
    expect_out("invalid_over_short", 1'b1, INVALID, 8'd1);

    // Short yellow alone
    pulse_reset();
    step(GRN, RED, 1'b0);
    step(YEL, RED, 1'b0);
    step(YEL, RED, 1'b0);
    step(RED, RED, 1'b0);
    expect_out("short_yel", 1'b1, SHORT_YEL, 8'd1);

    // GRN->RED bad sequence, code holds, then clear
    pulse_reset();
    step(GRN, RED, 1'b0);
    step(RED, RED, 1'b0);
    expect_out("bad_seq", 1'b1, BAD_SEQ, 8'd1);
    step(RED, RED, 1'b0);
    expect_out("bad_seq_hold", 1'b1, BAD_SEQ, 8'd1);
    step(RED, RED, 1'b1);
    expect_out("clear", 1'b0, NONE, 8'd1);
    step(RED, RED, 1'b1);
    expect_out("clear_idle", 1'b0, NONE, 8'd1);

    // Clear with a concurrent conflict latches the conflict and counts it
    step(GRN, RED, 1'b0);
    expect_out("legal_after_clear", 1'b0, NONE, 8'd1);
    step(RED, RED, 1'b0);
    expect_out("bad_seq_again", 1'b1, BAD_SEQ, 8'd2);
    step(GRN, GRN, 1'b1);
    expect_out("clear_vs_conflict", 1'b1, CONFLICT, 8'd3);
    step(3'b111, GRN, 1'b0);
    expect_out("code_frozen", 1'b1, CONFLICT, 8'd3);

    // Stuck: one change, then 64 unchanged cycles
    pulse_reset();
    step(RED, GRN, 1'b0);
    for (int i = 0; i < 63; i++) begin
      step(RED, GRN, 1'b0);
      check("stuck_early", {7'd0, fault}, 8'd0);
    end
    step(RED, GRN, 1'b0);
    expect_out("stuck", 1'b1, STUCK, 8'd1);

    // fault_cnt saturates: invalid with fault_clr re-latches every cycle
    pulse_reset();
    for (int i = 0; i < 260; i++) step(3'b111, RED, 1'b1);
    expect_out("cnt_saturate", 1'b1, INVALID, 8'd255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
